fig_14_block_504_cache_fill: RTL

//  Owns the 13-bit cache base register and the instruction-cache fill engine.

---
 rtl/fig_14_block_504_cache_fill_pkg.sv | 33 +++
 rtl/fig_14_block_504_cache_fill_if.sv | 27 ++
 rtl/fig_14_block_504_cache_fill_valid_bits.sv | 37 +++
 rtl/fig_14_block_504_cache_fill.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fig_14_block_504_cache_fill_pkg.sv
// Shared definitions for the instruction-cache fill engine.
// Geometry: 512-byte cache = 64 rows x 8 bytes, addressed by a 13-bit pc.
// Provides the row/byte index types, the fill FSM state type and a helper
// that aligns an address down to the start of its 8-byte row.
package fig_14_cache_pkg;

  localparam int PC_W       = 13;
  localparam int ROW_BITS   = 6;
  localparam int BYTE_BITS  = 3;
  localparam int CACHE_ROWS = 64;
  localparam int ROW_BYTES  = 8;

  typedef logic [ROW_BITS-1:0]  row_idx_t;
  typedef logic [BYTE_BITS-1:0] byte_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // Clears the byte-in-row bits; used for the base register on a rebase.
  function automatic logic [PC_W-1:0] row_align(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(ROW_BYTES - 1);
  endfunction

  // Byte address of the first byte of a cache row (wraps mod 2^PC_W).
  function automatic logic [PC_W-1:0] row_start(input logic [PC_W-1:0] base,
                                                input row_idx_t        row);
    return base + {{(PC_W-ROW_BITS-BYTE_BITS){1'b0}}, row, {BYTE_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/fig_14_block_504_cache_fill_if.sv
// Bus bundle of the fill engine: the ROM/RAM read channel plus the cache RAM
// write port.
//   rom_req/rom_addr   fill engine -> bus   read request, held until rom_ack
//   rom_ack/rom_data   bus -> fill engine   request accepted, data valid
//   cram_we/waddr/wdata fill engine -> RAM  one byte write per strobe
// master = fill engine side, slave = bus responder / RAM side.
interface fig_14_block_504_cache_fill_if;

  logic        rom_req;
  logic [12:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic        cram_we;
  logic [8:0]  cram_waddr;
  logic [7:0]  cram_wdata;

  modport master (
    output rom_req, rom_addr, cram_we, cram_waddr, cram_wdata,
    input  rom_ack, rom_data
  );

  modport slave (
    input  rom_req, rom_addr, cram_we, cram_waddr, cram_wdata,
    output rom_ack, rom_data
  );

endinterface

// File: rtl/fig_14_block_504_cache_fill_valid_bits.sv
// One valid flag per cache row.
//   clk, rst    clock, synchronous active-high reset (all rows invalid)
//   set_en      mark row set_row valid at the next edge
//   clear_all   invalidate every row at the next edge; wins over set_en
//   rd_row      row to look up, rd_valid is its flag (combinational)
module fig_14_cache_valid_bits
  import fig_14_cache_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  row_idx_t set_row,
  input  logic     clear_all,
  input  row_idx_t rd_row,
  output logic     rd_valid
);

  logic [CACHE_ROWS-1:0] valid_q;
  logic [CACHE_ROWS-1:0] valid_d;

  for (genvar gi = 0; gi < CACHE_ROWS; gi++) begin : g_row
    assign valid_d[gi] = clear_all ? 1'b0 :
                         (set_en && (set_row == row_idx_t'(gi))) ? 1'b1 :
                         valid_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rd_valid = valid_q[rd_row];

endmodule

// File: rtl/fig_14_block_504_cache_fill.sv
// Cache base register and instruction-cache row fill engine.
//   clk, rst         clock, synchronous active-high reset
//   pc               current program counter
//   orange           pc lies outside the cache window (from the window decoder)
//   cache_addr       row of pc within the window (from the window decoder)
//   fetch_req        core wants the byte at pc this cycle
//   cache_set        1-cycle CACHE instruction: rebase to pc's row, invalidate
//   cache_base_addr  base register driven to the window decoder
//   hit              fetch_req hits a valid row while the engine is idle
//   fill_busy        a row fill is in progress
//   bus              ROM read channel and cache RAM write port (master side)
// A miss fetches the 8 bytes of the row over the bus and writes them into the
// cache RAM one cycle after each ack. A CACHE instruction that arrives during
// a fill is parked and applied when the fill finishes, in place of marking
// the freshly filled row valid.
module fig_14_block_504_cache_fill
  import fig_14_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     pc,
  input  logic                orange,
  input  row_idx_t            cache_addr,
  input  logic                fetch_req,
  input  logic                cache_set,
  output logic [PC_W-1:0]     cache_base_addr,
  output logic                hit,
  output logic                fill_busy,
  fig_14_block_504_cache_fill_if.master bus
);

  fill_state_e     state_q, state_d;
  row_idx_t        row_q, row_d;
  byte_idx_t       beat_q, beat_d;
  logic            rom_req_q, rom_req_d;
  logic [PC_W-1:0] rom_addr_q, rom_addr_d;
  logic            cram_we_q, cram_we_d;
  logic [8:0]      cram_waddr_q, cram_waddr_d;
  logic [7:0]      cram_wdata_q, cram_wdata_d;
  logic [PC_W-1:0] base_q, base_d;
  logic            set_pend_q, set_pend_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;

  logic            row_valid;
  logic            vb_set;
  logic            vb_clear;
  logic            beat_accept;
  logic [PC_W-1:0] apply_pc;

  fig_14_cache_valid_bits u_valid_bits (
    .clk       (clk),
    .rst       (rst),
    .set_en    (vb_set),
    .set_row   (row_q),
    .clear_all (vb_clear),
    .rd_row    (cache_addr),
    .rd_valid  (row_valid)
  );

  assign beat_accept = rom_req_q && bus.rom_ack;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    beat_d       = beat_q;
    rom_req_d    = rom_req_q;
    rom_addr_d   = rom_addr_q;
    cram_we_d    = 1'b0;
    cram_waddr_d = cram_waddr_q;
    cram_wdata_d = cram_wdata_q;
    base_d       = base_q;
    set_pend_d   = set_pend_q;
    pend_pc_d    = pend_pc_q;
    vb_set       = 1'b0;
    vb_clear     = 1'b0;
    // A CACHE pulse landing exactly in DONE is applied together with any
    // parked one; the newest pc wins.
    apply_pc     = cache_set ? pc : pend_pc_q;

    case (state_q)
      IDLE: begin
        // cache_set beats a simultaneous miss; the core simply re-requests.
        if (cache_set) begin
          base_d   = row_align(pc);
          vb_clear = 1'b1;
        end else if (fetch_req && !orange && !row_valid) begin
          state_d    = FILL;
          row_d      = cache_addr;
          beat_d     = '0;
          rom_addr_d = row_start(base_q, cache_addr);
          rom_req_d  = 1'b1;
        end
      end

      FILL: begin
        if (cache_set) begin
          set_pend_d = 1'b1;
          pend_pc_d  = pc;
        end
        if (beat_accept) begin
          cram_we_d    = 1'b1;
          cram_waddr_d = {row_q, beat_q};
          cram_wdata_d = bus.rom_data;
          beat_d       = beat_q + 3'd1;
          rom_addr_d   = rom_addr_q + 13'd1;
          if (beat_q == byte_idx_t'(ROW_BYTES - 1)) begin
            rom_req_d = 1'b0;
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        // The last byte write is on the RAM port this cycle.
        if (set_pend_q || cache_set) begin
          base_d   = row_align(apply_pc);
          vb_clear = 1'b1;
        end else begin
          vb_set = 1'b1;
        end
        set_pend_d = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d   = IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      beat_q       <= '0;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= '0;
      cram_we_q    <= 1'b0;
      cram_waddr_q <= '0;
      cram_wdata_q <= '0;
      base_q       <= '0;
      set_pend_q   <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      beat_q       <= beat_d;
      rom_req_q    <= rom_req_d;
      rom_addr_q   <= rom_addr_d;
      cram_we_q    <= cram_we_d;
      cram_waddr_q <= cram_waddr_d;
      cram_wdata_q <= cram_wdata_d;
      base_q       <= base_d;
      set_pend_q   <= set_pend_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign fill_busy       = (state_q != IDLE);
  assign hit             = fetch_req && !orange && row_valid && !fill_busy;
  assign cache_base_addr = base_q;

  assign bus.rom_req    = rom_req_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.cram_we    = cram_we_q;
  assign bus.cram_waddr = cram_waddr_q;
  assign bus.cram_wdata = cram_wdata_q;

endmodule
